grf_sb: RTL

Parametrised general register file for the pipelined CPU: one write port, `NR` combinational read ports, write-through bypass, and a per-register pending scoreboard. Successor to the single-cycle GRF. It sits between decode (reads and destination issue) and writeback (write and pending clear), and supplies the stall logic with per-port hazard flags.

---
 rtl/grf_pkg.sv | 27 ++
 rtl/grf_sb_if.sv | 50 +++++
 rtl/grf_scoreboard.sv | 73 +++++++
 rtl/grf_sb.sv | 103 ++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// -----------------------------------------------------------------------------
// grf_pkg
// Shared constants for the pipelined general register file (grf_sb) and its
// pending-bit scoreboard.
//
// Contents:
//   GRF_DW    - default data width in bits
//   GRF_AW    - default address width (depth = 2**GRF_AW)
//   ZERO_REG  - architectural zero register (reads 0, never written/pending)
//   TRACE_FMT - simulation trace format for committed writes: pc, addr, data
//   is_zero_reg() - helper comparing an address against ZERO_REG
// -----------------------------------------------------------------------------
package grf_pkg;

    localparam int GRF_DW = 32;
    localparam int GRF_AW = 5;

    localparam int ZERO_REG = 0;

    localparam string TRACE_FMT = "@%h: $%d <= %h";

    // Width-agnostic zero-register test: every address bit must be clear.
    function automatic logic is_zero_reg(input logic [31:0] addr);
        return addr == 32'(ZERO_REG);
    endfunction

endpackage : grf_pkg

// File: rtl/grf_sb_if.sv
// -----------------------------------------------------------------------------
// grf_sb_if
// Bundles the decode/writeback-facing signals of the register file.
//
// Parameters: DW data width, AW address width, NR number of read ports.
// Signals:
//   pc    - PC of the instruction being written back (trace only)
//   we    - write enable
//   wa    - write address
//   wd    - write data
//   ra    - packed read addresses, port i at [i*AW +: AW]
//   rd    - packed read data,      port i at [i*DW +: DW]
//   rhaz  - per-port hazard flag
//   iss   - issue: mark destination ia pending
//   ia    - issue destination address
//   flush - clear all pending bits
// Modports:
//   master - pipeline side (drives addresses, write and issue controls)
//   slave  - register file side (drives read data and hazard flags)
// -----------------------------------------------------------------------------
interface grf_sb_if
    import grf_pkg::*;
#(
    parameter int DW = GRF_DW,
    parameter int AW = GRF_AW,
    parameter int NR = 2
) ();

    logic [DW-1:0]    pc;
    logic             we;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rhaz;
    logic             iss;
    logic [AW-1:0]    ia;
    logic             flush;

    modport master (
        output pc, we, wa, wd, ra, iss, ia, flush,
        input  rd, rhaz
    );

    modport slave (
        input  pc, we, wa, wd, ra, iss, ia, flush,
        output rd, rhaz
    );

endinterface : grf_sb_if

// File: rtl/grf_scoreboard.sv
// -----------------------------------------------------------------------------
// grf_scoreboard
// Per-register pending bits. A register becomes pending when decode issues an
// instruction that will write it, and stops being pending when writeback
// writes it. Flush drops every pending bit at once.
//
// Update order at each posedge (reset has precedence over all of it):
//   1. flush clears everything; we/iss are ignored for pending.
//   2. otherwise a write to wa clears pend[wa],
//   3. then an issue to ia sets pend[ia], so a same-cycle issue and writeback
//      to one register leaves it pending (the newer producer wins).
// The zero register is never pending.
//
// Ports:
//   clk   in  1        clock
//   reset in  1        synchronous active-high reset, clears all bits
//   flush in  1        clear all pending bits
//   we    in  1        writeback write enable
//   wa    in  AW       writeback address
//   iss   in  1        issue enable
//   ia    in  AW       issue destination address
//   pend  out 2**AW    current pending bits (bit 0 always 0)
// -----------------------------------------------------------------------------
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int AW = GRF_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic              iss,
    input  logic [AW-1:0]     ia,
    output logic [2**AW-1:0]  pend
);

    localparam int DEPTH = 2**AW;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    always_comb begin
        // NOTE: pend_d starts from the held value so every path assigns it;
        // without this default the partial bit updates would infer latches.
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            if (we && !is_zero_reg(32'(wa))) begin
                pend_d[wa] = 1'b0;
            end
            if (iss && !is_zero_reg(32'(ia))) begin
                pend_d[ia] = 1'b1;
            end
        end
        pend_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples its pre-edge inputs regardless of block order.
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule : grf_scoreboard

// File: rtl/grf_sb.sv
// -----------------------------------------------------------------------------
// grf_sb
// General register file for the pipelined CPU: one write port, NR
// combinational read ports with write-through bypass, and a per-register
// pending scoreboard feeding per-port hazard flags to the stall logic.
//
// Parameters:
//   DW  data width in bits
//   AW  address width, depth = 2**AW
//   NR  number of read ports (>= 1)
//
// Ports:
//   clk    in     1   clock
//   reset  in     1   synchronous active-high; clears all registers and
//                     pending bits, overrides write/issue/flush on that edge
//   bus    slave      grf_sb_if: pc, we, wa, wd, ra, iss, ia, flush in;
//                     rd, rhaz out
//
// Read port i (combinational, latency 0):
//   ra_i == 0                 -> rd_i = 0, rhaz_i = 0
//   we && wa == ra_i          -> rd_i = wd (bypass), rhaz_i = 0
//   otherwise                 -> rd_i = reg[ra_i], rhaz_i = pend[ra_i]
// Writes land at the posedge (latency 1); each committed write prints a
// trace line in simulation.
// -----------------------------------------------------------------------------
module grf_sb
    import grf_pkg::*;
#(
    parameter int DW = GRF_DW,
    parameter int AW = GRF_AW,
    parameter int NR = 2
) (
    input  logic      clk,
    input  logic      reset,
    grf_sb_if.slave   bus
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DEPTH-1:0] pend;
    logic             wr_en;

    // The zero register swallows writes entirely: no storage update, no trace.
    assign wr_en = bus.we && !is_zero_reg(32'(bus.wa));

    // -------------------------------------------------------------------------
    // Storage and write trace
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is reset explicitly because the architecture
            // requires every register to read 0 after reset; this forces
            // flops rather than a RAM macro, which is acceptable at this depth.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.wa] <= bus.wd;
`ifndef SYNTHESIS
            $display("%s", $sformatf(TRACE_FMT, bus.pc, bus.wa, bus.wd));
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Pending scoreboard
    // -------------------------------------------------------------------------
    grf_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk   (clk),
        .reset (reset),
        .flush (bus.flush),
        .we    (bus.we),
        .wa    (bus.wa),
        .iss   (bus.iss),
        .ia    (bus.ia),
        .pend  (pend)
    );

    // -------------------------------------------------------------------------
    // Read ports: bypass and hazard mux
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NR; g++) begin : g_rd
        logic [AW-1:0] ra_p;
        logic          nz;
        logic          hit;

        assign ra_p = bus.ra[g*AW +: AW];
        assign nz   = !is_zero_reg(32'(ra_p));
        // A write in flight to this register both supplies the data and
        // resolves the hazard within the same cycle.
        assign hit  = bus.we && (bus.wa == ra_p);

        assign bus.rd[g*DW +: DW] = !nz ? {DW{1'b0}}
                                  : hit ? bus.wd
                                  :       regs_q[ra_p];

        assign bus.rhaz[g] = nz && pend[ra_p] && !hit;
    end

endmodule : grf_sb
